axi_read_responder: RTL

- AXI3 read-channel slave: the responder end of the read address (AR) and read data (R) channels driven by the master in the DUV and bus-functional model.
- Accepts one AR request at a time and returns an ARLEN+1 beat burst on R from an internal word memory.
- Supports FIXED, INCR and WRAP bursts.
- Memory is preloaded through a backdoor write port.

---
 rtl/axi_read_responder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/axi_read_responder.sv
// AXI3 read-channel slave: accepts one AR request at a time and returns an
// ARLEN+1 beat FIXED/INCR/WRAP burst from a backdoor-loaded word memory.
module axi_read_responder #(
    parameter int WIDTH     = 32,
    parameter int SIZE      = 3,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH/8-1:0]   ARID,
    input  logic [WIDTH-1:0]     ARADDR,
    input  logic [WIDTH/8-1:0]   ARLEN,
    input  logic [SIZE-1:0]      ARSIZE,
    input  logic [SIZE-2:0]      ARBURST,
    input  logic                 ARVALID,
    output logic                 ARREADY,
    output logic [WIDTH/8-1:0]   RID,
    output logic [WIDTH-1:0]     RDATA,
    output logic [SIZE-2:0]      RRESP,
    output logic                 RLAST,
    output logic                 RVALID,
    input  logic                 RREADY,
    input  logic                 mem_we,
    input  logic [ADDR_BITS-1:0] mem_waddr,
    input  logic [WIDTH-1:0]     mem_wdata
);

    localparam int IDW      = WIDTH / 8;
    localparam int MAX_SIZE = $clog2(WIDTH / 8);

    localparam logic [SIZE-2:0] BURST_FIXED = '0;
    localparam logic [SIZE-2:0] BURST_WRAP  = {1'b1, {(SIZE-2){1'b0}}};
    localparam logic [SIZE-2:0] BURST_RSVD  = '1;
    localparam logic [SIZE-2:0] RESP_OKAY   = '0;
    localparam logic [SIZE-2:0] RESP_SLVERR = {1'b1, {(SIZE-2){1'b0}}};
    localparam logic [SIZE-2:0] RESP_DECERR = '1;

    typedef enum logic {S_IDLE, S_DATA} state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_mem [2**ADDR_BITS];
    logic [WIDTH-1:0]     r_addr;
    logic [IDW-1:0]       r_len;
    logic [IDW-1:0]       r_cnt;
    logic [SIZE-1:0]      r_size;
    logic [SIZE-2:0]      r_burst;
    logic                 r_slverr;
    logic [IDW-1:0]       r_rid;
    logic [WIDTH-1:0]     r_rdata;
    logic [SIZE-2:0]      r_rresp;
    logic                 r_rlast;
    logic                 r_rvalid;

    logic [WIDTH-1:0]     w_bytes;
    logic [WIDTH-1:0]     w_wrap_mask;
    logic [WIDTH-1:0]     w_next;
    logic [WIDTH-1:0]     w_ar_bytes;
    logic                 w_wrap_len_ok;
    logic                 w_ar_slverr;
    logic [WIDTH-1:0]     w_look_addr;
    logic                 w_look_err;
    logic [WIDTH-1:0]     w_rdata;
    logic [SIZE-2:0]      w_rresp;

    // ARREADY is decoded from state so it is already high in the first cycle after reset.
    assign ARREADY = (r_state == S_IDLE) && !reset;
    assign RID     = r_rid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;
    assign RLAST   = r_rlast;
    assign RVALID  = r_rvalid;

    always_comb begin
        w_bytes     = WIDTH'(1) << r_size;
        w_wrap_mask = ((WIDTH'(r_len) + WIDTH'(1)) << r_size) - WIDTH'(1);
        case (r_burst)
            BURST_FIXED: w_next = r_addr;
            BURST_WRAP:  w_next = (r_addr & ~w_wrap_mask) | ((r_addr + w_bytes) & w_wrap_mask);
            default:     w_next = (r_addr & ~(w_bytes - WIDTH'(1))) + w_bytes;
        endcase
    end

    always_comb begin
        w_ar_bytes    = WIDTH'(1) << ARSIZE;
        w_wrap_len_ok = (ARLEN == IDW'(1)) || (ARLEN == IDW'(3)) ||
                        (ARLEN == IDW'(7)) || (ARLEN == IDW'(15));
        w_ar_slverr   = (ARBURST == BURST_RSVD) ||
                        (ARSIZE > SIZE'(MAX_SIZE)) ||
                        ((ARBURST == BURST_WRAP) && !w_wrap_len_ok) ||
                        ((ARBURST == BURST_WRAP) && ((ARADDR & (w_ar_bytes - WIDTH'(1))) != '0));
    end

    // One lookup serves the first beat, the next beat, and the refresh of a stalled beat.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_look_addr = ARADDR;
            w_look_err  = w_ar_slverr;
        end else begin
            w_look_addr = RREADY ? w_next : r_addr;
            w_look_err  = r_slverr;
        end
        if (w_look_err) begin
            w_rdata = '0;
            w_rresp = RESP_SLVERR;
        end else if (w_look_addr[WIDTH-1:ADDR_BITS+2] != '0) begin
            w_rdata = '0;
            w_rresp = RESP_DECERR;
        end else begin
            w_rdata = r_mem[w_look_addr[ADDR_BITS+1:2]];
            w_rresp = RESP_OKAY;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            r_mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_slverr <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= '0;
            r_rlast  <= 1'b0;
            r_rvalid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ARVALID) begin
                        r_addr   <= ARADDR;
                        r_len    <= ARLEN;
                        r_size   <= ARSIZE;
                        r_burst  <= ARBURST;
                        r_slverr <= w_ar_slverr;
                        r_cnt    <= '0;
                        r_rid    <= ARID;
                        r_rdata  <= w_rdata;
                        r_rresp  <= w_rresp;
                        r_rlast  <= (ARLEN == '0);
                        r_rvalid <= 1'b1;
                        r_state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (RREADY) begin
                        if (r_cnt == r_len) begin
                            r_rvalid <= 1'b0;
                            r_rlast  <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_addr  <= w_next;
                            r_cnt   <= r_cnt + IDW'(1);
                            r_rlast <= ((r_cnt + IDW'(1)) == r_len);
                            r_rdata <= w_rdata;
                            r_rresp <= w_rresp;
                        end
                    end else begin
                        r_rdata <= w_rdata;
                        r_rresp <= w_rresp;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
